des_expand_serializer: RTL and testbench
========================================

# des_expand_serializer

Upstream feeder for the shared, time-multiplexed DES S-box stage. Accepts one 32-bit right half and one 48-bit round subkey, applies the DES E-expansion and XORs the result with the subkey. The 48-bit product is then streamed as eight 6-bit chunks, S1 first through S8 last, over a valid/ready handshake. The downstream S-box mux selects SBox1..SBox8 with `sbox_idx` and reassembles the 32-bit result.

## Interface
- No parameters; all widths are fixed by DES.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  `r_in`/`subkey_in` valid
- `in_ready`  out  1  block can accept a new half-block
- `r_in`  in  [1:32]  right half R; bit 1 = MSB (DES numbering)
- `subkey_in`  in  [1:48]  round subkey K; bit 1 = MSB
- `sbox_valid`  out  1  chunk on `sbox_data` valid
- `sbox_ready`  in  1  downstream accepts chunk
- `sbox_data`  out  [1:6]  6-bit S-box input b1..b6 (b1,b6 = row, b2..b5 = column)
- `sbox_idx`  out  3  S-box select; 0 = S1 … 7 = S8
- `sbox_last`  out  1  high with chunk 7 (S8)

## Operation
- E table (output bit order): 32 1 2 3 4 5 | 4 5 6 7 8 9 | 8..13 | 12..17 | 16..21 | 20..25 | 24..29 | 28 29 30 31 32 1.
- `X[1:48] = E(r_in) ^ subkey_in` is captured into a 48-bit working register on input acceptance.
- Chunk i (i = 0..7) is `X[6i+1 : 6i+6]`. `sbox_idx` = i. `sbox_last` = (i == 7).
- States:
  - IDLE: `sbox_valid`=0. `in_ready`=1. `in_valid` moves the block to SEND with i=0.
  - SEND: `sbox_valid`=1. When `sbox_ready` is high, i increments.
  - On acceptance of chunk 7: if `in_valid` is high in the same cycle, load the new block and stay in SEND with i=0. Otherwise go to IDLE.
- `in_ready` = IDLE, or (SEND and i==7 and `sbox_ready`). Combinational from registered state and `sbox_ready`.
- Handshake rules:
  - While `sbox_valid` && !`sbox_ready`, `sbox_data`, `sbox_idx` and `sbox_last` hold stable.
  - `sbox_valid` is never withdrawn before it is accepted.
- Inputs are sampled only on the accepting edge. Changes to `r_in`/`subkey_in` afterward do not affect chunks already in flight.
- Reset values (while `rst_n`=0 and after release): state IDLE, i=0, working register 0, `sbox_valid`=0, `sbox_data`=0, `sbox_idx`=0, `sbox_last`=0.
- `in_ready`=0 while `rst_n`=0.
- Reset mid-block: the remaining chunks are discarded. The first cycle after release is IDLE.

## Timing
- Input accepted at edge T: chunk 0 is valid after edge T, i.e. visible in cycle T+1.
- With `sbox_ready` held high, chunk i is presented in cycle T+1+i.
- Sustained throughput is one block per 8 cycles with no idle bubble between blocks.
- Each cycle `sbox_ready` is low adds exactly one cycle of stall. There is no skid buffer.

## Configuration
- `DES_ZEROIZE_EN` defined:
  - The working register is cleared to 0 on the edge chunk 7 is accepted, unless a new block loads on that edge.
  - `sbox_data` is forced to 0 whenever `sbox_valid`=0.
  - No key-derived material persists after a block completes.
- `DES_ZEROIZE_EN` undefined:
  - The register retains the last value.
  - `sbox_data` shows the last chunk while idle.
  - Functional handshake behaviour is identical.

## Test plan
- Single block, `sbox_ready`=1: `r_in`=32'hF0AAF0AA, `subkey_in`=48'h1B02EFFC7072 gives X=48'h6117BA866527.
  - Chunks in cycles T+1..T+8: 011000, 010001, 011110, 111010, 100001, 100110, 010100, 100111.
  - `sbox_idx` 0..7; `sbox_last` only on the 8th chunk; IDLE in cycle T+9.
- Backpressure: same vectors, `sbox_ready` low for 3 cycles while chunk 2 is shown.
  - Chunk 2 = 011110 and `sbox_idx`=2 hold for 4 cycles.
  - Total completion is T+11.
- Back-to-back: second block (`r_in`=0, `subkey_in`=0) held valid during chunk 7 of the first.
  - `in_ready` is high that cycle, the second block loads, and chunk 0 = 000000 follows with no gap.
- Input change after accept: alter `r_in` at T+2. Emitted chunks remain those of F0AAF0AA.
- Reset mid-block: `rst_n`=0 during chunk 4, released after 1 cycle.
  - All outputs are 0 during reset.
  - IDLE with `in_ready`=1 the cycle after release; no further chunks.
- Zeroize check: after block completion with `DES_ZEROIZE_EN`, `sbox_data`=0 while idle.
  - Without the macro, `sbox_data`=100111 while idle.

Source files
------------

// File: rtl/des_expand_serializer.sv
// DES E-expansion XOR round subkey, streamed to the shared S-box stage as eight 6-bit chunks.
// Optional macro DES_ZEROIZE_EN: wipe the working register and idle sbox_data once a block completes.
module des_expand_serializer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:32] r_in,
   input  logic [1:48] subkey_in,
   output logic        sbox_valid,
   input  logic        sbox_ready,
   output logic [1:6]  sbox_data,
   output logic [2:0]  sbox_idx,
   output logic        sbox_last
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [1:48] work_q, work_d;
   logic        sbox_valid_q, sbox_valid_d;
   logic        sbox_last_q, sbox_last_d;
   logic [1:6]  sbox_data_q, sbox_data_d;
   logic [1:48] e_out, x_in;
   logic        load, chunk_acc;

   function automatic logic [1:6] chunk_of(input logic [1:48] w, input logic [2:0] i);
      case (i)
         3'd0:    return w[1:6];
         3'd1:    return w[7:12];
         3'd2:    return w[13:18];
         3'd3:    return w[19:24];
         3'd4:    return w[25:30];
         3'd5:    return w[31:36];
         3'd6:    return w[37:42];
         default: return w[43:48];
      endcase
   endfunction

   // E table: each 6-bit group overlaps its neighbours by one bit, wrapping 32 <-> 1.
   assign e_out = {r_in[32], r_in[1:5], r_in[4:9], r_in[8:13], r_in[12:17],
                   r_in[16:21], r_in[20:25], r_in[24:29], r_in[28:32], r_in[1]};
   assign x_in  = e_out ^ subkey_in;

   assign in_ready  = rst_n && ((state_q == IDLE) ||
                                (state_q == SEND && idx_q == 3'd7 && sbox_ready));
   assign load      = in_valid && in_ready;
   assign chunk_acc = (state_q == SEND) && sbox_ready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      work_d  = work_q;
      if (load) begin
         state_d = SEND;
         idx_d   = 3'd0;
         work_d  = x_in;
      end else if (chunk_acc) begin
         if (idx_q == 3'd7) begin
            state_d = IDLE;
            idx_d   = 3'd0;
`ifdef DES_ZEROIZE_EN
            work_d  = '0;
`endif
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end

      sbox_valid_d = (state_d == SEND);
      sbox_last_d  = (state_d == SEND) && (idx_d == 3'd7);
      if (state_d == SEND) begin
         sbox_data_d = chunk_of(work_d, idx_d);
      end else begin
`ifdef DES_ZEROIZE_EN
         sbox_data_d = '0;
`else
         sbox_data_d = sbox_data_q;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         work_q       <= '0;
         sbox_valid_q <= 1'b0;
         sbox_last_q  <= 1'b0;
         sbox_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         work_q       <= work_d;
         sbox_valid_q <= sbox_valid_d;
         sbox_last_q  <= sbox_last_d;
         sbox_data_q  <= sbox_data_d;
      end
   end

   assign sbox_valid = sbox_valid_q;
   assign sbox_data  = sbox_data_q;
   assign sbox_idx   = idx_q;
   assign sbox_last  = sbox_last_q;

endmodule

// File: tb/tb_des_expand_serializer.sv
// Directed bench for des_expand_serializer: single block, backpressure, back-to-back, input hold, reset.
module tb_des_expand_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:32] r_in;
   logic [1:48] subkey_in;
   logic        sbox_valid;
   logic        sbox_ready;
   logic [1:6]  sbox_data;
   logic [2:0]  sbox_idx;
   logic        sbox_last;

   int checks = 0;
   int errors = 0;

   // Hand-derived chunks for r=F0AAF0AA, K=1B02EFFC7072 (X=6117BA866527).
   localparam logic [5:0] EXP [0:7] = '{6'b011000, 6'b010001, 6'b011110, 6'b111010,
                                        6'b100001, 6'b100110, 6'b010100, 6'b100111};
   // r=00000001, K=0: bit 32 lands in E positions 1 and 47.
   localparam logic [5:0] EXP_W [0:7] = '{6'b100000, 6'b000000, 6'b000000, 6'b000000,
                                          6'b000000, 6'b000000, 6'b000000, 6'b000010};
`ifdef DES_ZEROIZE_EN
   localparam logic [5:0] IDLE_DATA = 6'b000000;
`else
   localparam logic [5:0] IDLE_DATA = 6'b100111;
`endif

   des_expand_serializer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .r_in       (r_in),
      .subkey_in  (subkey_in),
      .sbox_valid (sbox_valid),
      .sbox_ready (sbox_ready),
      .sbox_data  (sbox_data),
      .sbox_idx   (sbox_idx),
      .sbox_last  (sbox_last)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; sbox_ready = 1'b1;
      r_in = 32'hF0AAF0AA; subkey_in = 48'h1B02EFFC7072;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || sbox_valid !== 1'b0 || sbox_data !== 6'b0 ||
          sbox_idx !== 3'd0 || sbox_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b v=%b d=%b i=%0d l=%b exp 0 0 000000 0 0",
                  in_ready, sbox_valid, sbox_data, sbox_idx, sbox_last);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || sbox_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got rdy=%b v=%b exp 1 0", in_ready, sbox_valid);
      end
   endtask

   task automatic test_single();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_in_ready got %b exp 1", in_ready);
      end
      in_valid = 1'b1; r_in = 32'hF0AAF0AA; subkey_in = 48'h1B02EFFC7072;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         checks++;
         if (sbox_valid !== 1'b1 || sbox_data !== EXP[i] || sbox_idx !== i[2:0] ||
             sbox_last !== (i == 7)) begin
            errors++;
            $display("FAIL single_chunk%0d got v=%b d=%b i=%0d l=%b exp 1 %b %0d %b",
                     i, sbox_valid, sbox_data, sbox_idx, sbox_last, EXP[i], i, (i == 7));
         end
      end
      @(negedge clk);
      checks++;
      if (sbox_valid !== 1'b0 || in_ready !== 1'b1 || sbox_last !== 1'b0) begin
         errors++;
         $display("FAIL single_idle got v=%b rdy=%b l=%b exp 0 1 0", sbox_valid, in_ready, sbox_last);
      end
      checks++;
      if (sbox_data !== IDLE_DATA) begin
         errors++;
         $display("FAIL idle_data got %b exp %b", sbox_data, IDLE_DATA);
      end
   endtask

   task automatic test_backpressure();
      int ei;
      in_valid = 1'b1; r_in = 32'hF0AAF0AA; subkey_in = 48'h1B02EFFC7072;
      for (int cyc = 1; cyc <= 11; cyc++) begin
         @(negedge clk);
         in_valid = 1'b0;
         ei = (cyc <= 3) ? cyc - 1 : (cyc <= 6) ? 2 : cyc - 4;
         sbox_ready = !(cyc >= 3 && cyc <= 5);
         checks++;
         if (sbox_valid !== 1'b1 || sbox_data !== EXP[ei] || sbox_idx !== ei[2:0] ||
             in_ready !== (cyc == 11)) begin
            errors++;
            $display("FAIL bp_cycle%0d got v=%b d=%b i=%0d rdy=%b exp 1 %b %0d %b",
                     cyc, sbox_valid, sbox_data, sbox_idx, in_ready, EXP[ei], ei, (cyc == 11));
         end
      end
      @(negedge clk);
      checks++;
      if (sbox_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_done got v=%b exp 0", sbox_valid);
      end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; r_in = 32'hF0AAF0AA; subkey_in = 48'h1B02EFFC7072;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (i == 7) begin
            in_valid = 1'b1; r_in = 32'h0; subkey_in = 48'h0;
            checks++;
            if (in_ready !== 1'b1 || sbox_data !== EXP[7]) begin
               errors++;
               $display("FAIL b2b_ready got rdy=%b d=%b exp 1 %b", in_ready, sbox_data, EXP[7]);
            end
         end
      end
      // Second block (all zero); chain a third block on its chunk 7.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         checks++;
         if (sbox_valid !== 1'b1 || sbox_data !== 6'b0 || sbox_idx !== i[2:0]) begin
            errors++;
            $display("FAIL b2b_blk2_chunk%0d got v=%b d=%b i=%0d exp 1 000000 %0d",
                     i, sbox_valid, sbox_data, sbox_idx, i);
         end
         if (i == 7) begin
            in_valid = 1'b1; r_in = 32'h00000001; subkey_in = 48'h0;
         end
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         checks++;
         if (sbox_valid !== 1'b1 || sbox_data !== EXP_W[i] || sbox_idx !== i[2:0]) begin
            errors++;
            $display("FAIL b2b_wrap_chunk%0d got v=%b d=%b i=%0d exp 1 %b %0d",
                     i, sbox_valid, sbox_data, sbox_idx, EXP_W[i], i);
         end
      end
      @(negedge clk);
      checks++;
      if (sbox_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_idle got v=%b rdy=%b exp 0 1", sbox_valid, in_ready);
      end
   endtask

   task automatic test_input_change();
      in_valid = 1'b1; r_in = 32'hF0AAF0AA; subkey_in = 48'h1B02EFFC7072;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (i == 1) begin
            r_in = 32'h12345678; subkey_in = 48'hFFFF0000FFFF;
         end
         checks++;
         if (sbox_valid !== 1'b1 || sbox_data !== EXP[i]) begin
            errors++;
            $display("FAIL hold_chunk%0d got v=%b d=%b exp 1 %b", i, sbox_valid, sbox_data, EXP[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_block();
      in_valid = 1'b1; r_in = 32'hF0AAF0AA; subkey_in = 48'h1B02EFFC7072;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      checks++;
      if (sbox_idx !== 3'd4 || sbox_data !== EXP[4]) begin
         errors++;
         $display("FAIL midrst_pre got i=%0d d=%b exp 4 %b", sbox_idx, sbox_data, EXP[4]);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || sbox_valid !== 1'b0 || sbox_data !== 6'b0 ||
          sbox_idx !== 3'd0 || sbox_last !== 1'b0) begin
         errors++;
         $display("FAIL midrst_during got rdy=%b v=%b d=%b i=%0d l=%b exp 0 0 000000 0 0",
                  in_ready, sbox_valid, sbox_data, sbox_idx, sbox_last);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1 || sbox_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after%0d got rdy=%b v=%b exp 1 0", c, in_ready, sbox_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_input_change();
      test_reset_mid_block();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
